game_timer_bcd: RTL

//  Parametrised countdown game timer for the two-player sequence-matching game. It holds an
//  N-digit BCD time value and decrements it once every PRESCALE clocks while running. It

---
 rtl/game_timer_bcd_if.sv | 25 ++
 rtl/game_timer_bcd.sv | 134 +++++++++++++
 2 files changed

// File: rtl/game_timer_bcd_if.sv
// Control and display bundle between the game FSM / display and the BCD countdown timer.
// The timer side uses the slave modport and the controller side uses the master modport.
interface game_timer_bcd_if #(
  parameter int NUM_DIGITS = 3
);
  logic                    Load;
  logic [4*NUM_DIGITS-1:0] LoadVal;
  logic                    Start;
  logic                    Pause;
  logic [4*NUM_DIGITS-1:0] Digits;
  logic                    Running;
  logic                    Stop;
  logic                    Expired;
  logic                    Warn;

  modport master (
    output Load, LoadVal, Start, Pause,
    input  Digits, Running, Stop, Expired, Warn
  );

  modport slave (
    input  Load, LoadVal, Start, Pause,
    output Digits, Running, Stop, Expired, Warn
  );
endinterface

// File: rtl/game_timer_bcd.sv
// N-digit BCD countdown timer with a prescaler, load/start/pause control,
// a warning threshold and sticky expiry for the sequence-matching game.
module game_timer_bcd #(
  parameter int NUM_DIGITS = 3,
  parameter int PRESCALE   = 1000,
  parameter int WARN_VAL   = 10
) (
  input  logic             Clk,
  input  logic             Rst,
  game_timer_bcd_if.slave  bus
);
  localparam int DW = 4 * NUM_DIGITS;
  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PSC_LAST = PW'(PRESCALE - 1);

  typedef enum logic [1:0] {IDLE, RUN, PAUSE, EXPIRED} state_t;

  state_t        state;
  logic [PW-1:0] psc;
  logic [DW-1:0] digits_q;
  logic          running_q, stop_q, expired_q, warn_q;
  logic [DW-1:0] dec_val, ld_val;

  function automatic logic [DW-1:0] bcd_clamp(input logic [DW-1:0] v);
    logic [DW-1:0] r;
    r = v;
    for (int i = 0; i < NUM_DIGITS; i++)
      if (v[i*4 +: 4] > 4'd9) r[i*4 +: 4] = 4'd9;
    return r;
  endfunction

  // Subtract one unit; a zero digit becomes 9 and passes the borrow upward.
  function automatic logic [DW-1:0] bcd_dec(input logic [DW-1:0] v);
    logic [DW-1:0] r;
    logic          borrow;
    r      = v;
    borrow = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (borrow) begin
        if (v[i*4 +: 4] == 4'd0) begin
          r[i*4 +: 4] = 4'd9;
        end else begin
          r[i*4 +: 4] = v[i*4 +: 4] - 4'd1;
          borrow      = 1'b0;
        end
      end
    end
    return r;
  endfunction

  function automatic logic in_warn(input logic [DW-1:0] v);
    int b;
    b = 0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--)
      b = b * 10 + int'(v[i*4 +: 4]);
    return (b > 0) && (b <= WARN_VAL);
  endfunction

  always_comb begin
    dec_val = bcd_dec(digits_q);
    ld_val  = bcd_clamp(bus.LoadVal);
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state     <= IDLE;
      psc       <= '0;
      digits_q  <= '0;
      running_q <= 1'b0;
      stop_q    <= 1'b0;
      expired_q <= 1'b0;
      warn_q    <= 1'b0;
    end else begin
      expired_q <= 1'b0;
      if (bus.Load) begin
        state     <= IDLE;
        psc       <= '0;
        digits_q  <= ld_val;
        warn_q    <= in_warn(ld_val);
        running_q <= 1'b0;
        stop_q    <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (bus.Start) begin
              if (digits_q == '0) begin
                state     <= EXPIRED;
                stop_q    <= 1'b1;
                expired_q <= 1'b1;
              end else begin
                state     <= RUN;
                psc       <= '0;
                running_q <= 1'b1;
              end
            end
          end
          RUN: begin
            // The pause edge itself does not advance the prescaler.
            if (bus.Pause) begin
              state     <= PAUSE;
              running_q <= 1'b0;
            end else if (psc == PSC_LAST) begin
              psc      <= '0;
              digits_q <= dec_val;
              warn_q   <= in_warn(dec_val);
              if (dec_val == '0) begin
                state     <= EXPIRED;
                running_q <= 1'b0;
                stop_q    <= 1'b1;
                expired_q <= 1'b1;
              end
            end else begin
              psc <= psc + PW'(1);
            end
          end
          PAUSE: begin
            if (bus.Start) begin
              state     <= RUN;
              running_q <= 1'b1;
            end
          end
          EXPIRED: ;
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign bus.Digits  = digits_q;
  assign bus.Running = running_q;
  assign bus.Stop    = stop_q;
  assign bus.Expired = expired_q;
  assign bus.Warn    = warn_q;
endmodule
